// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter for the write side of an asynchronous FIFO.
// Owns the write pointer, synchronizes the read pointer and derives the full flag and occupancy.
`timescale 1ns/1ps
module fifo_wr_arb #(
    parameter int D_WIDTH = 8,
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*DATA_W-1:0]  wdata_in,
    input  logic [D_WIDTH:0]         rptr_gray,
    output logic [N_REQ-1:0]         gnt,
    output logic                     wen,
    output logic [D_WIDTH-1:0]       waddr,
    output logic [DATA_W-1:0]        wdata,
    output logic [D_WIDTH:0]         wptr_gray,
    output logic                     full,
    output logic [D_WIDTH:0]         wlevel
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [D_WIDTH:0] rq1_q, rq2_q;
    logic [D_WIDTH:0] wbin_q, wbin_d;
    logic [D_WIDTH:0] wgray_q, wgray_d;
    logic [D_WIDTH:0] wlevel_q, wlevel_d;
    logic [D_WIDTH:0] rbinSync;
    logic             full_q, full_d;
    logic [PW-1:0]    prio_q, prio_d;
    logic [PW-1:0]    gntIdx, cand;
    logic             found, accept;

    function automatic logic [PW-1:0] wrapAdd(input logic [PW-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % N_REQ;
        return PW'(sum);
    endfunction

    function automatic logic [D_WIDTH:0] gray2bin(input logic [D_WIDTH:0] g);
        logic [D_WIDTH:0] b;
        b[D_WIDTH] = g[D_WIDTH];
        for (int i = D_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin
        found  = 1'b0;
        gntIdx = '0;
        cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrapAdd(prio_q, k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                gntIdx = cand;
            end
        end
    end

    assign accept = found & ~full_q & rst_n;
    assign gnt    = accept ? (N_REQ'(1) << gntIdx) : '0;
    assign wen    = accept;
    assign waddr  = wbin_q[D_WIDTH-1:0];
    assign wdata  = wdata_in[gntIdx*DATA_W +: DATA_W];

    // Full/level look at the post-edge write count so they are valid right after the accept.
    always_comb begin
        wbin_d   = wbin_q + {{D_WIDTH{1'b0}}, accept};
        wgray_d  = wbin_d ^ (wbin_d >> 1);
        prio_d   = accept ? wrapAdd(gntIdx, 1) : prio_q;
        rbinSync = gray2bin(rq2_q);
        full_d   = (wgray_d == {~rq2_q[D_WIDTH -: 2], rq2_q[D_WIDTH-2:0]});
        wlevel_d = wbin_d - rbinSync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq1_q    <= '0;
            rq2_q    <= '0;
            wbin_q   <= '0;
            wgray_q  <= '0;
            full_q   <= 1'b0;
            wlevel_q <= '0;
            prio_q   <= '0;
        end else begin
            rq1_q    <= rptr_gray;
            rq2_q    <= rq1_q;
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            full_q   <= full_d;
            wlevel_q <= wlevel_d;
            prio_q   <= prio_d;
        end
    end

    assign wptr_gray = wgray_q;
    assign full      = full_q;
    assign wlevel    = wlevel_q;
endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, FIFO address width (depth 2^D_WIDTH).
REQ-002 SHALL have parameter N_REQ, default 4, number of write requesters (2..8).
REQ-003 SHALL have parameter DATA_W, default 32, write data width.
REQ-004 SHALL have port clk  input  1  single write-domain clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req  input  N_REQ  per-requester write request, level.
REQ-007 SHALL have port wdata_in  input  N_REQ*DATA_W  requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port rptr_gray  input  D_WIDTH+1  read-domain Gray pointer, asynchronous to clk.
REQ-009 SHALL have port gnt  output  N_REQ  one-hot grant; a write is accepted from requester i in the cycle gnt[i]=1.
REQ-010 SHALL have port wen  output  1  FIFO RAM write enable.
REQ-011 SHALL have port waddr  output  D_WIDTH  FIFO RAM write address.
REQ-012 SHALL have port wdata  output  DATA_W  FIFO RAM write data, from the granted requester.
REQ-013 SHALL have port wptr_gray  output  D_WIDTH+1  registered write Gray pointer, for the read domain.
REQ-014 SHALL have port full  output  1  registered FIFO-full flag.
REQ-015 SHALL have port wlevel  output  D_WIDTH+1  registered occupancy estimate, write-domain view.

Function
REQ-016 SHALL pass rptr_gray through a 2-flop synchronizer (rq2) clocked by clk before any use.
REQ-017 SHALL hold a binary write counter wbin[D_WIDTH:0] and register wptr_gray = wbin ^ (wbin >> 1).
REQ-018 SHALL drive waddr = wbin[D_WIDTH-1:0] and wdata = the granted requester's slice, both combinational in the accept cycle.
REQ-019 SHALL grant combinationally, same cycle as req: gnt = 0 when full=1; otherwise one-hot to the first requester with req=1, searching from priority pointer prio upward, modulo N_REQ.
REQ-020 SHALL drive wen = |gnt; at most one write per cycle.
REQ-021 SHALL, on an accept edge, increment wbin by 1 (wrapping modulo 2^(D_WIDTH+1)) and set prio to (granted index + 1) mod N_REQ.
REQ-022 SHALL leave wbin and prio unchanged in cycles with no grant, including cycles with req pending while full=1.
REQ-023 SHALL register full <= (wgray_nxt == {~rq2[D_WIDTH:D_WIDTH-1], rq2[D_WIDTH-2:0]}), where wgray_nxt is the Gray code of the post-edge wbin.
REQ-024 SHALL never assert full spuriously on an empty FIFO; full SHALL deassert no earlier than 2 clk edges after rptr_gray advances.
REQ-025 SHALL register wlevel <= wbin_nxt - gray2bin(rq2), computed modulo 2^(D_WIDTH+1), range 0..2^D_WIDTH.
REQ-026 SHALL keep requester i's req asserted until gnt[i]; dropping req before grant SHALL be legal and withdraw the request.
REQ-027 SHALL change wptr_gray by exactly one bit per accept, including the wrap from 1000..0 to 0000..0.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously clear wbin, wptr_gray, both synchronizer stages, full, wlevel, and set prio=0.
REQ-029 SHALL, during reset, hold gnt=0 and wen=0 regardless of req.
REQ-030 SHALL, on reset mid-burst, abandon any in-flight request without a partial write; the first post-reset grant follows REQ-019 with prio=0.

Verification (bench uses D_WIDTH=3, N_REQ=4, DATA_W=8)
REQ-031 SHALL verify reset: rst_n=0 with req=4'b1111 -> gnt=0, wen=0, wptr_gray=0, full=0, wlevel=0.
REQ-032 SHALL verify round-robin: req=4'b1111 held, rptr_gray=0 -> gnt sequence 0001,0010,0100,1000,0001...; waddr 0,1,2,3,...
REQ-033 SHALL verify full: 8 accepts with rptr_gray=0 -> full=1 after the 8th edge, wptr_gray=4'b1100, wlevel=8; a 9th req -> gnt=0, wen=0.
REQ-034 SHALL verify drain release: from full, rptr_gray=4'b0001 -> full=0 within 3 edges, wlevel=7; next accept writes waddr=0.
REQ-035 SHALL verify wrap: 16 accepts with rptr_gray tracking -> wbin returns to 0, every wptr_gray step is single-bit, waddr cycles 0..7 twice.
REQ-036 SHALL verify priority skip: prio=2, req=4'b0011 -> gnt=4'b0001, next prio=1; async rst_n pulse mid-sequence -> prio=0, pointers 0.
